// File: rtl/mux_pkg.sv
// mux_pkg: mode constants and select-width helper shared by mux_arb_reg and rr_arbiter.
package mux_pkg;

    localparam int MODE_SELECT = 0;
    localparam int MODE_RR = 1;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_reg_rr_arbiter.sv
// rr_arbiter: round-robin grant searching upward from ptr+1; ptr moves to the grant only on advance.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SELW = sel_w(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] req,
    input  logic              advance,
    output logic [NUM_IN-1:0] grant,
    output logic [SELW-1:0]   idx,
    output logic              any
);

    logic [SELW-1:0] ptr;
    int best;
    int d;

    // Lowest rotated distance from ptr+1 wins, so a skipped requester keeps its place.
    always_comb begin
        best = NUM_IN;
        d = 0;
        idx = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            d = (j + 2 * NUM_IN - int'(ptr) - 1) % NUM_IN;
            if (req[j] && d < best) begin
                best = d;
                idx = SELW'(j);
            end
        end
        any = best < NUM_IN;
        grant = any ? NUM_IN'(1) << idx : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= SELW'(NUM_IN - 1);
        else if (advance) ptr <= idx;
    end

endmodule

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: registered N:1 mux with valid/ready, sel or round-robin channel choice.
// Optional transfer counter xfer_cnt enabled by defining MUX_STATS_EN.
module mux_arb_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NUM_IN = 4,
    parameter int MODE = MODE_SELECT,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [sel_w(NUM_IN)-1:0]  sel,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [sel_w(NUM_IN)-1:0]  out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MUX_STATS_EN
    ,
    output logic [CNT_W-1:0]          xfer_cnt
`endif
);

    localparam int SELW = sel_w(NUM_IN);

    logic [WIDTH-1:0] ch [NUM_IN];
    logic [SELW-1:0] g;
    logic [NUM_IN-1:0] oh;
    logic has_g;
    logic can_load;
    logic accept;

    if (NUM_IN < 2 || CNT_W < 1) begin : g_bad_param
        $error("mux_arb_reg: NUM_IN must be >= 2 and CNT_W >= 1");
    end

    for (genvar k = 0; k < NUM_IN; k++) begin : g_ch
        assign ch[k] = in_data[k*WIDTH +: WIDTH];
    end

    if (MODE == MODE_RR) begin : g_rr
        rr_arbiter #(.NUM_IN(NUM_IN), .SELW(SELW)) u_arb (
            .clk(clk),
            .rst_n(rst_n),
            .req(in_valid),
            .advance(accept),
            .grant(oh),
            .idx(g),
            .any(has_g)
        );
    end else begin : g_sel
        // Out-of-range sel (non-power-of-2 NUM_IN) simply yields no grant.
        assign g = sel;
        assign has_g = int'(sel) < NUM_IN;
        assign oh = has_g ? NUM_IN'(1) << sel : '0;
    end

    assign can_load = !out_valid || out_ready;
    assign in_ready = can_load ? oh : '0;
    assign accept = |(in_valid & in_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_chan <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data <= ch[g];
            out_chan <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xfer_cnt <= '0;
        else if (out_valid && out_ready && !(&xfer_cnt)) xfer_cnt <= xfer_cnt + 1'b1;
    end
`endif

endmodule
